// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared types and constants for the binary pixel packer
package edge_pkg;

    // Packer state: waiting for a frame start, or filling words of a frame
    typedef enum logic {
        ST_IDLE,
        ST_PACK
    } state_t;

    // Default number of pixels per packed word
    localparam int WORD_W_DEF = 8;

    // Width of the empty-count field for a given word width
    function automatic int calc_mty_w(input int word_w);
        return $clog2(word_w);
    endfunction

endpackage

// File: rtl/bin_pack.sv
// rtl/bin_pack.sv - packs a 1-bit pixel stream into WORD_W-bit words with sop/eop/mty framing (option: BIN_PACK_MSB_FIRST_EN)
module bin_pack
    import edge_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int MTY_W  = calc_mty_w(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic [WORD_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [MTY_W-1:0]  dout_mty,
    output logic              err
);

    localparam logic [MTY_W-1:0] CNT_LAST = MTY_W'(WORD_W - 1);

    state_t            r_state;
    logic [WORD_W-1:0] r_shift;
    logic [MTY_W-1:0]  r_cnt;
    logic              r_first;

    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_sop_word;
    logic              w_word_done;

    // Bit slot inside the word for the pixel with index idx; padding ends up
    // at the opposite end from the first pixel
    function automatic logic [MTY_W-1:0] bit_pos(input logic [MTY_W-1:0] idx);
`ifdef BIN_PACK_MSB_FIRST_EN
        return CNT_LAST - idx;
`else
        return idx;
`endif
    endfunction

    // Candidate words: the buffer with the current pixel merged in, and a fresh
    // word holding only the current pixel (used when a frame starts)
    always_comb begin
        w_word      = r_shift | (WORD_W'(din) << bit_pos(r_cnt));
        w_sop_word  = WORD_W'(din) << bit_pos('0);
        w_word_done = din_eop || (r_cnt == CNT_LAST);
    end

    // Framing FSM, shift buffer and registered word outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_first  <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_mty <= '0;
            err      <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            err      <= 1'b0;
            if (din_vld) begin
                if (din_sop) begin
                    // A sop inside a frame abandons the buffered partial word
                    if (r_state == ST_PACK) begin
                        err <= 1'b1;
                    end
                    if (din_eop) begin
                        dout     <= w_sop_word;
                        dout_vld <= 1'b1;
                        dout_sop <= 1'b1;
                        dout_eop <= 1'b1;
                        dout_mty <= CNT_LAST;
                        r_shift  <= '0;
                        r_cnt    <= '0;
                        r_first  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_shift  <= w_sop_word;
                        r_cnt    <= MTY_W'(1);
                        r_first  <= 1'b1;
                        r_state  <= ST_PACK;
                    end
                end else if (r_state == ST_IDLE) begin
                    // Pixel outside any frame: dropped
                    err <= 1'b1;
                end else begin
                    if (w_word_done) begin
                        dout     <= w_word;
                        dout_vld <= 1'b1;
                        dout_sop <= r_first;
                        dout_eop <= din_eop;
                        dout_mty <= din_eop ? (CNT_LAST - r_cnt) : '0;
                        r_shift  <= '0;
                        r_cnt    <= '0;
                        r_first  <= 1'b0;
                    end else begin
                        r_shift  <= w_word;
                        r_cnt    <= r_cnt + MTY_W'(1);
                    end
                    if (din_eop) begin
                        r_state <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_pack.sv
// tb/tb_bin_pack.sv - directed self-checking bench for bin_pack with WORD_W=8
module tb_bin_pack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_vld;
    logic       din_sop;
    logic       din_eop;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_sop;
    logic       dout_eop;
    logic [2:0] dout_mty;
    logic       err;

    int n_total = 0;
    int n_pass  = 0;

`ifdef BIN_PACK_MSB_FIRST_EN
    localparam logic [7:0] EXP_A0 = 8'hB1;
    localparam logic [7:0] EXP_A1 = 8'h69;
    localparam logic [7:0] EXP_B1 = 8'hE0;
    localparam logic [7:0] EXP_S  = 8'h80;
    localparam logic [7:0] EXP_R  = 8'hAA;
    localparam logic [7:0] EXP_F  = 8'hCB;
`else
    localparam logic [7:0] EXP_A0 = 8'h8D;
    localparam logic [7:0] EXP_A1 = 8'h96;
    localparam logic [7:0] EXP_B1 = 8'h07;
    localparam logic [7:0] EXP_S  = 8'h01;
    localparam logic [7:0] EXP_R  = 8'h55;
    localparam logic [7:0] EXP_F  = 8'hD3;
`endif

    bin_pack #(.WORD_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_mty (dout_mty),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic chk_word(input string tag, input logic [7:0] w, input logic s,
                            input logic e, input logic [2:0] m);
        chk({tag, ".vld"}, 32'(dout_vld), 32'd1);
        chk({tag, ".dout"}, 32'(dout), 32'(w));
        chk({tag, ".sop"}, 32'(dout_sop), 32'(s));
        chk({tag, ".eop"}, 32'(dout_eop), 32'(e));
        chk({tag, ".mty"}, 32'(dout_mty), 32'(m));
    endtask

    // Present one pixel for one clock; returns at the next falling edge
    task automatic beat(input logic d, input logic s, input logic e);
        din     = d;
        din_vld = 1'b1;
        din_sop = s;
        din_eop = e;
        @(negedge clk);
        din     = 1'b0;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    initial begin
        logic [15:0] pa;
        logic [7:0]  pr;
        logic [7:0]  pf;
        pa = 16'h968D;
        pr = 8'b0101_0101;
        pf = 8'b1101_0011;

        rst_n = 1'b0; din = 1'b0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.vld", 32'(dout_vld), 32'd0);
        chk("rst.dout", 32'(dout), 32'd0);
        chk("rst.mty", 32'(dout_mty), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 16-pixel frame: two full words
        for (int i = 0; i < 16; i++) begin
            beat(pa[i], i == 0, i == 15);
            if (i == 7)       chk_word("A.w0", EXP_A0, 1'b1, 1'b0, 3'd0);
            else if (i == 15) chk_word("A.w1", EXP_A1, 1'b0, 1'b1, 3'd0);
            else              chk("A.novld", 32'(dout_vld), 32'd0);
        end
        @(negedge clk);
        chk("A.pulse", 32'(dout_vld), 32'd0);
        chk("A.hold", 32'(dout), 32'(EXP_A1));

        // 11 ones: full word then a 3-pixel tail with 5 padded slots
        for (int i = 0; i < 11; i++) begin
            beat(1'b1, i == 0, i == 10);
            if (i == 7)       chk_word("B.w0", 8'hFF, 1'b1, 1'b0, 3'd0);
            else if (i == 10) chk_word("B.w1", EXP_B1, 1'b0, 1'b1, 3'd5);
            else              chk("B.novld", 32'(dout_vld), 32'd0);
        end
        @(negedge clk);

        // Single-pixel frame
        beat(1'b1, 1'b1, 1'b1);
        chk_word("S", EXP_S, 1'b1, 1'b1, 3'd7);
        chk("S.err", 32'(err), 32'd0);
        @(negedge clk);

        // Pixels with no frame open are dropped with an error each
        for (int i = 0; i < 2; i++) begin
            beat(1'b1, 1'b0, 1'b0);
            chk("D.err", 32'(err), 32'd1);
            chk("D.novld", 32'(dout_vld), 32'd0);
        end
        @(negedge clk);
        chk("D.errclr", 32'(err), 32'd0);

        // Restart: sop on beat 3 abandons the 3-pixel partial word
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        chk("R.noerr", 32'(err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            beat(pr[i], i == 0, i == 7);
            if (i == 0) begin
                chk("R.err", 32'(err), 32'd1);
                chk("R.novld0", 32'(dout_vld), 32'd0);
            end else if (i == 7) begin
                chk_word("R.w", EXP_R, 1'b1, 1'b1, 3'd0);
                chk("R.errw", 32'(err), 32'd0);
            end else begin
                chk("R.novld", 32'(dout_vld), 32'd0);
            end
        end
        @(negedge clk);

        // Reset after 5 pixels: nothing stale comes out
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("M.rst.vld", 32'(dout_vld), 32'd0);
        chk("M.rst.dout", 32'(dout), 32'd0);
        chk("M.rst.sop", 32'(dout_sop), 32'd0);
        chk("M.rst.eop", 32'(dout_eop), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("M.idle", 32'(dout_vld), 32'd0);
        for (int i = 0; i < 8; i++) begin
            beat(pf[i], i == 0, i == 7);
            if (i == 7) chk_word("M.w", EXP_F, 1'b1, 1'b1, 3'd0);
            else        chk("M.novld", 32'(dout_vld), 32'd0);
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
